// File: rtl/pcie_ep_mem_responder.sv
// PCIe endpoint memory target: services MWr32/MRd32 request TLPs against a DW memory
// and returns CplD/Cpl TLPs, in acceptance order, through a small completion FIFO.
module pcie_ep_mem_responder #(
  parameter int DEPTH     = 256,
  parameter int CPL_DEPTH = 4,
  parameter int CNT_W     = 16
) (
  input  logic             PCIE_CLK,
  input  logic             PCIE_RST,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [127:0]     req_tlp,
  output logic             cpl_valid,
  input  logic             cpl_ready,
  output logic [127:0]     cpl_tlp,
  output logic [CNT_W-1:0] mwr_cnt,
  output logic [CNT_W-1:0] mrd_cnt,
  output logic [CNT_W-1:0] ur_cnt
);
  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // The requester must hold req_tlp while req_valid && !req_ready; the block holds
  // cpl_tlp while cpl_valid && !cpl_ready.
  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(CPL_DEPTH);
  localparam logic [FW:0] CPL_MAX = CPL_DEPTH[FW:0];

  localparam logic [7:0] T_MWR  = 8'h40;
  localparam logic [7:0] T_MRD  = 8'h00;
  localparam logic [7:0] T_CPLD = 8'h4A;
  localparam logic [7:0] T_CPL  = 8'h0A;

  logic [31:0]     r_mem [DEPTH];
  logic [127:0]    r_fifo [CPL_DEPTH];
  logic [FW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [FW:0]     r_count;
  logic            r_stg_valid;
  logic [127:0]    r_stg_tlp;
  logic [CNT_W-1:0] r_mwr_cnt, r_mrd_cnt, r_ur_cnt;

  logic [7:0]      w_type;
  logic [31:0]     w_addr;
  logic [AW-1:0]   w_word;
  logic            w_good, w_is_mwr, w_is_mrd, w_rd_ok;
  logic            w_accept, w_push, w_pop;
  logic [FW:0]     w_occ;
  logic [127:0]    w_cpl_new;
  logic            w_unused_rsvd;

  assign w_type   = req_tlp[127:120];
  assign w_addr   = req_tlp[95:64];
  assign w_word   = w_addr[AW+1:2];
  assign w_good   = (w_addr[1:0] == 2'b00) && (w_addr[31:AW+2] == '0);
  assign w_is_mwr = (w_type == T_MWR);
  assign w_is_mrd = (w_type == T_MRD);
  assign w_rd_ok  = w_is_mrd && w_good;
  assign w_unused_rsvd = ^req_tlp[63:32];

  // Stage slot counts toward occupancy so its push can never find the FIFO full.
  assign w_occ     = r_count + {{FW{1'b0}}, r_stg_valid};
  assign req_ready = !PCIE_RST && (w_occ < CPL_MAX);
  assign w_accept  = req_valid && req_ready;

  assign w_push    = r_stg_valid;
  assign cpl_valid = (r_count != '0);
  assign w_pop     = cpl_valid && cpl_ready;
  assign cpl_tlp   = cpl_valid ? r_fifo[r_rd_ptr] : '0;

  assign w_cpl_new = w_rd_ok
    ? {T_CPLD, req_tlp[119:112], req_tlp[111:96], 3'b000, 61'b0, r_mem[w_word]}
    : {T_CPL,  req_tlp[119:112], req_tlp[111:96], 3'b001, 61'b0, 32'h0};

  assign mwr_cnt = r_mwr_cnt;
  assign mrd_cnt = r_mrd_cnt;
  assign ur_cnt  = r_ur_cnt;

  // Memory is deliberately left out of reset.
  always_ff @(posedge PCIE_CLK) begin
    if (w_accept && w_is_mwr && w_good) r_mem[w_word] <= req_tlp[31:0];
  end

  always_ff @(posedge PCIE_CLK) begin
    if (PCIE_RST) begin
      r_stg_valid <= 1'b0;
      r_stg_tlp   <= '0;
    end else begin
      r_stg_valid <= w_accept && !w_is_mwr;
      if (w_accept && !w_is_mwr) r_stg_tlp <= w_cpl_new;
    end
  end

  always_ff @(posedge PCIE_CLK) begin
    if (w_push) r_fifo[r_wr_ptr] <= r_stg_tlp;
  end

  always_ff @(posedge PCIE_CLK) begin
    if (PCIE_RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge PCIE_CLK) begin
    if (PCIE_RST) begin
      r_mwr_cnt <= '0;
      r_mrd_cnt <= '0;
      r_ur_cnt  <= '0;
    end else if (w_accept) begin
      if (w_is_mwr) begin
        if (w_good) r_mwr_cnt <= r_mwr_cnt + 1'b1;
        else        r_ur_cnt  <= r_ur_cnt + 1'b1;
      end else if (w_rd_ok) begin
        r_mrd_cnt <= r_mrd_cnt + 1'b1;
      end else begin
        r_ur_cnt <= r_ur_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pcie_ep_mem_responder.sv
// Directed bench for pcie_ep_mem_responder: completions are scored against an expected
// queue filled from a small request model; key cases also use hand-built constants.
module tb_pcie_ep_mem_responder;
  logic         PCIE_CLK, PCIE_RST;
  logic         req_valid, req_ready;
  logic [127:0] req_tlp;
  logic         cpl_valid, cpl_ready;
  logic [127:0] cpl_tlp;
  logic [15:0]  mwr_cnt, mrd_cnt, ur_cnt;

  pcie_ep_mem_responder #(.DEPTH(256), .CPL_DEPTH(4), .CNT_W(16)) dut (
    .PCIE_CLK(PCIE_CLK), .PCIE_RST(PCIE_RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_tlp(req_tlp),
    .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_tlp(cpl_tlp),
    .mwr_cnt(mwr_cnt), .mrd_cnt(mrd_cnt), .ur_cnt(ur_cnt)
  );

  // clock / reset
  initial PCIE_CLK = 1'b0;
  always #5 PCIE_CLK = ~PCIE_CLK;

  int           n_tests = 0;
  int           n_fail  = 0;
  int           n_pop   = 0;
  bit           acc;
  logic [127:0] exp_q[$];
  logic [31:0]  mem_m [256];
  int           e_mwr = 0, e_mrd = 0, e_ur = 0;

  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  function automatic logic [127:0] mk_req(input logic [7:0] typ, input logic [7:0] tag,
                                          input logic [15:0] rid, input logic [31:0] addr,
                                          input logic [31:0] data);
    return {typ, tag, rid, addr, 32'h0, data};
  endfunction

  // Request model: updates the memory image, counters and expected completions.
  task automatic model_accept(input logic [127:0] tlp);
    logic [31:0] addr;
    logic        good;
    addr = tlp[95:64];
    good = (addr[1:0] == 2'b00) && (addr[31:10] == 22'h0);
    if (tlp[127:120] == 8'h40) begin
      if (good) begin mem_m[addr[9:2]] = tlp[31:0]; e_mwr++; end
      else e_ur++;
    end else if (tlp[127:120] == 8'h00 && good) begin
      exp_q.push_back({8'h4A, tlp[119:112], tlp[111:96], 3'b000, 61'b0, mem_m[addr[9:2]]});
      e_mrd++;
    end else begin
      exp_q.push_back({8'h0A, tlp[119:112], tlp[111:96], 3'b001, 61'b0, 32'h0});
      e_ur++;
    end
  endtask

  // One clock: score any completion handshake, note request acceptance, advance.
  task automatic step();
    if (cpl_valid && cpl_ready) begin
      n_pop++;
      if (exp_q.size() == 0) check("cpl_unexpected", cpl_valid, 1'b0);
      else check("cpl_tlp", cpl_tlp, exp_q.pop_front());
    end
    acc = req_valid && req_ready;
    @(posedge PCIE_CLK);
    #1;
  endtask

  task automatic issue(input logic [127:0] tlp);
    bit done;
    done = 0;
    req_valid = 1'b1;
    req_tlp   = tlp;
    for (int i = 0; i < 40 && !done; i++) begin
      step();
      if (acc) begin model_accept(tlp); done = 1; end
    end
    req_valid = 1'b0;
    check("issue_accepted", done, 1'b1);
  endtask

  task automatic drain();
    cpl_ready = 1'b1;
    for (int i = 0; i < 80 && exp_q.size() != 0; i++) step();
    check("drain_empty", exp_q.size(), 0);
    step();
    check("drain_cpl_valid", cpl_valid, 1'b0);
  endtask

  task automatic check_cnts(input string name);
    check({name, "_mwr"}, mwr_cnt, e_mwr[15:0]);
    check({name, "_mrd"}, mrd_cnt, e_mrd[15:0]);
    check({name, "_ur"},  ur_cnt,  e_ur[15:0]);
  endtask

  initial begin
    int k, pops0;
    logic [127:0] t;
    PCIE_RST  = 1'b1;
    req_valid = 1'b0;
    req_tlp   = '0;
    cpl_ready = 1'b0;
    repeat (3) step();

    // reset then idle
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_cpl_valid", cpl_valid, 1'b0);
    check("rst_cpl_tlp", cpl_tlp, 128'h0);
    check_cnts("rst");
    PCIE_RST = 1'b0;
    step();
    check("post_rst_req_ready", req_ready, 1'b1);
    check("post_rst_cpl_valid", cpl_valid, 1'b0);

    // write then read-after-write on the next cycle, with latency check
    issue(mk_req(8'h40, 8'h05, 16'h0100, 32'h10, 32'hDEADBEEF));
    issue(mk_req(8'h00, 8'h06, 16'h0100, 32'h10, 32'h0));
    check("raw_lat_edge1", cpl_valid, 1'b0);
    step();
    check("raw_lat_edge2", cpl_valid, 1'b1);
    check("raw_cpld", cpl_tlp, {8'h4A, 8'h06, 16'h0100, 3'b000, 61'b0, 32'hDEADBEEF});
    drain();
    check("raw_mwr_cnt", mwr_cnt, 16'd1);
    check("raw_mrd_cnt", mrd_cnt, 16'd1);

    // unsupported / bad-address requests
    issue(mk_req(8'h00, 8'h11, 16'h0100, 32'h400, 32'h0));
    step();
    check("ur_rd_cpl", cpl_tlp, {8'h0A, 8'h11, 16'h0100, 3'b001, 93'b0});
    drain();
    check("ur_rd_cnt", ur_cnt, 16'd1);
    issue(mk_req(8'h40, 8'h12, 16'h0100, 32'h402, 32'h12345678));
    repeat (3) step();
    check("ur_wr_no_cpl", cpl_valid, 1'b0);
    check("ur_wr_cnt", ur_cnt, 16'd2);
    cpl_ready = 1'b0;
    issue(mk_req(8'h20, 8'h13, 16'h0300, 32'h20, 32'h0));
    step();
    check("ur_type_cpl", cpl_tlp, {8'h0A, 8'h13, 16'h0300, 3'b001, 93'b0});
    drain();
    check_cnts("ur");

    // preload words 64..79
    for (int i = 0; i < 16; i++)
      issue(mk_req(8'h40, 8'h00, 16'h0, 32'h100 + 32'(4 * i), 32'hA500_0000 + 32'(i)));

    // backpressure: 6 reads offered with cpl_ready low, only 4 fit
    cpl_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 8; c++) begin
      req_valid = (k < 6);
      t = mk_req(8'h00, 8'(8'h20 + k), 16'h0400, 32'h100 + 32'(4 * k), 32'h0);
      req_tlp = t;
      step();
      if (acc) begin model_accept(t); k++; end
    end
    check("bp_accepted", k, 4);
    check("bp_req_ready", req_ready, 1'b0);
    check("bp_cpl_valid", cpl_valid, 1'b1);
    check("bp_head", cpl_tlp, exp_q[0]);
    repeat (2) step();
    check("bp_head_held", cpl_tlp, {8'h4A, 8'h20, 16'h0400, 3'b000, 61'b0, 32'hA500_0000});
    req_valid = 1'b0;
    cpl_ready = 1'b1;
    step();
    check("bp_reopen", req_ready, 1'b1);
    issue(mk_req(8'h00, 8'h24, 16'h0400, 32'h110, 32'h0));
    issue(mk_req(8'h00, 8'h25, 16'h0400, 32'h114, 32'h0));
    drain();
    check_cnts("bp");

    // streaming 16 reads with cpl_ready toggling every cycle
    pops0 = n_pop;
    k = 0;
    for (int c = 0; c < 200 && (k < 16 || exp_q.size() != 0); c++) begin
      cpl_ready = c[0];
      req_valid = (k < 16);
      t = mk_req(8'h00, 8'(8'h40 + k), 16'h0500, 32'h100 + 32'(4 * (k % 16)), 32'h0);
      req_tlp = t;
      step();
      if (acc) begin model_accept(t); k++; end
    end
    req_valid = 1'b0;
    check("stream_accepted", k, 16);
    check("stream_pops", n_pop - pops0, 16);
    drain();
    check_cnts("stream");

    // reset with completions queued
    cpl_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      issue(mk_req(8'h00, 8'(8'h60 + i), 16'h0600, 32'h100 + 32'(4 * i), 32'h0));
    repeat (2) step();
    check("pre_rst_cpl_valid", cpl_valid, 1'b1);
    PCIE_RST = 1'b1;
    step();
    exp_q.delete();
    e_mwr = 0; e_mrd = 0; e_ur = 0;
    check("mid_rst_cpl_valid", cpl_valid, 1'b0);
    check("mid_rst_cpl_tlp", cpl_tlp, 128'h0);
    check("mid_rst_req_ready", req_ready, 1'b0);
    check_cnts("mid_rst");
    PCIE_RST  = 1'b0;
    cpl_ready = 1'b1;
    step();
    check("after_rst_req_ready", req_ready, 1'b1);
    repeat (4) step();
    check("after_rst_no_stale", cpl_valid, 1'b0);
    cpl_ready = 1'b0;
    issue(mk_req(8'h00, 8'h77, 16'h0200, 32'h100, 32'h0));
    step();
    check("mem_kept", cpl_tlp, {8'h4A, 8'h77, 16'h0200, 3'b000, 61'b0, 32'hA500_0000});
    drain();
    check("after_rst_mrd_cnt", mrd_cnt, 16'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pcie_ep_mem_responder.md
Name: pcie_ep_mem_responder

Overview:
- Endpoint-side target that consumes Memory Read/Write request TLPs from the host request channel (req_*) and produces completion TLPs on the completion channel (cpl_*).
- Backs a DEPTH x 32-bit DW memory and queues completions in a CPL_DEPTH-entry FIFO, so the host may keep issuing while completions are stalled.
- Serves as the DUT behind the dut_mp modport of the PCIe interface.

Parameters:
- DEPTH, 256, number of 32-bit DWs in the target memory (power of 2)
- CPL_DEPTH, 4, completion FIFO entries (power of 2, >=2)
- CNT_W, 16, width of the statistics counters

Ports:
- PCIE_CLK  in  1  sole clock, all logic on rising edge
- PCIE_RST  in  1  reset, synchronous, active-high
- req_valid  in  1  request TLP valid
- req_ready  out  1  block can accept a request this cycle
- req_tlp  in  128  request TLP: [127:120] type (0x40 MWr32, 0x00 MRd32), [119:112] tag, [111:96] requester_id, [95:64] byte address, [63:32] reserved, [31:0] write data
- cpl_valid  out  1  completion TLP valid
- cpl_ready  in  1  host accepts completion
- cpl_tlp  out  128  completion TLP: [127:120] type (0x4A CplD, 0x0A Cpl), [119:112] tag, [111:96] requester_id, [95:93] status (000 SC, 001 UR), [92:32] zero, [31:0] read data (zero for Cpl)
- mwr_cnt  out  CNT_W  accepted successful MWr count
- mrd_cnt  out  CNT_W  accepted successful MRd count
- ur_cnt  out  CNT_W  unsupported/erroneous request count

Behaviour:
- Reset (PCIE_RST high at an edge) forces the following values: req_ready=0, cpl_valid=0, cpl_tlp=0, all counters=0, FIFO empty, pipeline stage empty.
  - Memory contents are not affected by reset.
  - Reset mid-operation discards queued and in-flight completions.
  - req_ready returns to 1 on the first cycle after reset deasserts.
- Accept condition: req_valid && req_ready at a rising edge.
  - req_ready = !PCIE_RST && (fifo_count + stage_valid < CPL_DEPTH).
  - Counting the stage slot guarantees the FIFO never overflows.
- Decode of an accepted request:
  - MWr, good address: mem[word] <= data at the accept edge. Posted, so no completion. mwr_cnt++.
  - MRd, good address: the stage register captures tag, requester_id and mem[word] at the accept edge. CplD/SC is pushed at the next edge. mrd_cnt++.
  - Good address means addr[1:0]==0 and addr[31:2] < DEPTH; word = addr[$clog2(DEPTH)+1:2].
  - MRd with a bad address, or any other type value: Cpl with status UR and data 0, same timing as CplD. ur_cnt++.
  - MWr with a bad address: silently dropped, ur_cnt++, no completion.
- Latency: the completion is visible on cpl_valid no earlier than 2 edges after the accept edge (stage edge, then FIFO output register).
- Ordering: completions leave in request acceptance order.
- Read-after-write: an MWr accepted at edge N followed by an MRd to the same word at edge N+1 returns the new data.
- Completion handshake: cpl_valid = FIFO non-empty. cpl_tlp is stable while cpl_valid && !cpl_ready. Pop on cpl_valid && cpl_ready.
- A push and a pop in the same cycle are both honoured; the count is unchanged. This holds when full and when there is one entry.
- Counters wrap modulo 2^CNT_W.
- Back-to-back accepts at 1 per cycle are sustained while cpl_ready=1.

Test Plan:
- Reset then idle:
  - Required values: req_ready=0 during reset, req_ready=1 one cycle after; cpl_valid=0; counters 0.
- MWr addr 0x10 data 0xDEADBEEF tag 0x05, then MRd addr 0x10 tag 0x06 req_id 0x0100 on the next cycle:
  - One cpl_tlp with type 0x4A, tag 0x06, req_id 0x0100, status 000, data 0xDEADBEEF.
  - mwr_cnt=1, mrd_cnt=1.
- MRd addr 0x400 (DEPTH=256) tag 0x11:
  - Cpl type 0x0A, status 001, data 0, ur_cnt=1.
  - MWr addr 0x402: no completion, ur_cnt=2.
  - Type 0x20 request: Cpl UR.
- cpl_ready=0, issue 6 MRd:
  - Exactly 4 accepted; req_ready drops to 0 and cpl_tlp is held stable.
  - Raising cpl_ready drains tags in order and re-opens req_ready.
- Streaming 16 MRd with cpl_ready toggling 1/0 each cycle:
  - No loss or duplication; tags return in order; simultaneous push/pop is exercised at full and at one entry.
- Assert PCIE_RST with 3 completions queued:
  - cpl_valid=0 the next cycle and no stale completion after reset.
  - Previously written memory data is still readable.
